// File: rtl/word_byte_fifo.sv
// word_byte_fifo: DEPTH-word FIFO of 16-bit samples drained as bytes, low byte first.
module word_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [15:0]              word_in,
  input  logic                     word_valid,
  output logic [7:0]               byte_out,
  output logic                     byte_valid,
  input  logic                     byte_ack,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          phase;
  logic          full, xfer, pop, push, drop;
  logic [15:0]   head;
  assign head       = mem[rd_ptr];
  assign byte_valid = level != '0;
  assign byte_out   = phase ? head[15:8] : head[7:0];
  assign full       = level == (AW+1)'(DEPTH);
  assign xfer       = enable & byte_valid & byte_ack;
  assign pop        = xfer & phase;
  // a full FIFO can still take a word when the head word leaves on the same edge
  assign push       = enable & word_valid & (~full | pop);
  assign drop       = enable & word_valid & full & ~pop;
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      phase    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (xfer) phase <= ~phase;
      if (drop) overflow <= 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word_in;
  end
endmodule

// File: tb/tb_word_byte_fifo.sv
// tb_word_byte_fifo: word queue model checked every cycle plus directed literal expectations.
module tb_word_byte_fifo;
  localparam int DEPTH = 8;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0, enable = 1'b1, word_valid = 1'b0, byte_ack = 1'b0;
  logic [15:0] word_in = '0;
  logic [7:0]  byte_out;
  logic        byte_valid, overflow;
  logic [3:0]  level;
  int          checks = 0, errors = 0;
  logic [15:0] mq[$];
  bit          mph = 0, mov = 0, popping, room;

  word_byte_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .word_in(word_in), .word_valid(word_valid),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ack(byte_ack), .level(level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  // Model: a queue of whole words plus which half of the head word is on offer.
  always @(posedge clk) begin
    if (!rst_n || !enable) begin
      mq.delete();
      mph = 0;
      mov = 0;
    end else begin
      popping = mq.size() != 0 && byte_ack && mph;
      room = mq.size() < DEPTH || popping;
      if (mq.size() != 0 && byte_ack) begin
        if (mph) begin
          void'(mq.pop_front());
          mph = 0;
        end else mph = 1;
      end
      if (word_valid) begin
        if (room) mq.push_back(word_in);
        else mov = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("byte_valid", 16'(byte_valid), 16'(mq.size() != 0));
    chk("level", 16'(level), 16'(mq.size()));
    chk("overflow", 16'(overflow), 16'(mov));
    if (mq.size() != 0) chk("byte_out", 16'(byte_out), 16'(mph ? mq[0][15:8] : mq[0][7:0]));
  end

  task automatic cyc(input logic wv, input logic [15:0] w, input logic ack,
                     input logic en = 1'b1, input logic rn = 1'b1);
    word_valid = wv;
    word_in = w;
    byte_ack = ack;
    enable = en;
    rst_n = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(string n, logic bv, logic [3:0] lv, logic ov);
    chk({n, "_bv"}, 16'(byte_valid), 16'(bv));
    chk({n, "_level"}, 16'(level), 16'(lv));
    chk({n, "_ovf"}, 16'(overflow), 16'(ov));
  endtask

  task automatic take(string n, logic [7:0] b);
    chk(n, 16'({byte_valid, byte_out}), 16'({1'b1, b}));
    cyc(1'b0, 16'h0, 1'b1);
  endtask

  initial begin
    int pushed, n;
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    expect_state("reset", 1'b0, 4'd0, 1'b0);
    // single word, ack held high from the push cycle
    cyc(1'b1, 16'hA55A, 1'b1);
    expect_state("single_push", 1'b1, 4'd1, 1'b0);
    chk("single_lo", 16'(byte_out), 16'h5A);
    cyc(1'b0, 16'h0, 1'b1);
    chk("single_hi", 16'(byte_out), 16'hA5);
    cyc(1'b0, 16'h0, 1'b1);
    expect_state("single_done", 1'b0, 4'd0, 1'b0);
    // fill past full
    for (int i = 1; i <= 9; i++) cyc(1'b1, 16'(i), 1'b0);
    expect_state("fill", 1'b1, 4'd8, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      take("fill_lo", 8'(i));
      take("fill_hi", 8'h00);
    end
    expect_state("fill_empty", 1'b0, 4'd0, 1'b1);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    expect_state("flush", 1'b0, 4'd0, 1'b0);
    // full with simultaneous pop and push
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'h10 + 16'(i), 1'b0);
    take("full_lo", 8'h10);
    chk("full_ph1", 16'(byte_out), 16'h00);
    cyc(1'b1, 16'h1234, 1'b1);
    expect_state("full_pop", 1'b1, 4'd8, 1'b0);
    for (int i = 1; i < 8; i++) begin
      take("full_drain_lo", 8'h10 + 8'(i));
      take("full_drain_hi", 8'h00);
    end
    take("full_last_lo", 8'h34);
    take("full_last_hi", 8'h12);
    expect_state("full_end", 1'b0, 4'd0, 1'b0);
    // wrap: 20 words with random ack
    pushed = 0;
    n = 0;
    while (pushed < 20 && n < 2000) begin
      if (n % 2 == 0 && mq.size() < DEPTH) begin
        cyc(1'b1, {8'hA0 + 8'(pushed), 8'(pushed * 7)}, 1'($urandom_range(0, 1)));
        pushed++;
      end else cyc(1'b0, 16'h0, 1'($urandom_range(0, 1)));
      n++;
    end
    chk("wrap_pushed", 16'(pushed), 16'd20);
    n = 0;
    while (byte_valid && n < 200) begin
      cyc(1'b0, 16'h0, 1'b1);
      n++;
    end
    expect_state("wrap_end", 1'b0, 4'd0, 1'b0);
    // mid-word flush
    cyc(1'b1, 16'hBEEF, 1'b1);
    chk("beef_lo", 16'(byte_out), 16'hEF);
    cyc(1'b0, 16'h0, 1'b1);
    chk("beef_hi_pending", 16'(byte_out), 16'hBE);
    cyc(1'b1, 16'h1111, 1'b1, 1'b0);
    expect_state("midflush", 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1);
    expect_state("midflush_after", 1'b0, 4'd0, 1'b0);
    // reset mid-operation
    for (int i = 0; i < 9; i++) cyc(1'b1, 16'h2000 + 16'(i), 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 16'h0, 1'b1);
    expect_state("pre_reset", 1'b1, 4'd5, 1'b1);
    cyc(1'b1, 16'h3333, 1'b1, 1'b1, 1'b0);
    expect_state("mid_reset", 1'b0, 4'd0, 1'b0);
    cyc(1'b1, 16'h00FF, 1'b0);
    take("reset_lo", 8'hFF);
    take("reset_hi", 8'h00);
    expect_state("reset_end", 1'b0, 4'd0, 1'b0);
    // reset in the middle of a word discards the high byte
    cyc(1'b1, 16'h5678, 1'b1);
    cyc(1'b0, 16'h0, 1'b1);
    chk("midword_hi", 16'(byte_out), 16'h56);
    cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    expect_state("midword_reset", 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/word_byte_fifo.md
WORD_BYTE_FIFO -- requirements
Module: word_byte_fifo

Interface
REQ-001: Parameter DEPTH, default 8, SHALL set the FIFO depth in 16-bit words; legal values are powers of two from 2 to 64.
REQ-002: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003: rst_n  input  1  SHALL be the reset, synchronous and active-low.
REQ-004: enable  input  1  SHALL run the block when high; when low, the block flushes synchronously.
REQ-005: word_in  input  16  SHALL carry the parallel sample word from the serial-to-parallel stage.
REQ-006: word_valid  input  1  SHALL be the one-cycle strobe marking word_in as valid; it connects to the upstream ready output.
REQ-007: byte_out  output  8  SHALL carry the byte presented to the host FIFO writer.
REQ-008: byte_valid  output  1  SHALL be high when byte_out holds a valid byte.
REQ-009: byte_ack  input  1  SHALL be the consumer acceptance of the current byte.
REQ-010: level  output  log2(DEPTH)+1  SHALL give the number of words stored, counting a partially sent word.
REQ-011: overflow  output  1  SHALL be a sticky flag showing that at least one word was dropped.

Function
REQ-012: The block SHALL be a DEPTH-entry circular FIFO of 16-bit words with a write pointer, a read pointer, a level counter and a 1-bit byte phase.
REQ-013: A push SHALL occur when enable=1, word_valid=1 and the FIFO is not full, or when the FIFO is full and a pop completes in the same cycle.
REQ-014: If word_valid=1, enable=1, the FIFO is full and no pop completes that cycle, the word SHALL be dropped and overflow SHALL be set on the next edge.
REQ-015: overflow SHALL stay set until reset or until enable is low.
REQ-016: byte_valid SHALL equal (level != 0), driven from registered state only.
REQ-017: With phase=0, byte_out SHALL be head word bits [7:0]; with phase=1, it SHALL be head word bits [15:8]; the low byte goes first.
REQ-018: A transfer SHALL occur when byte_valid=1 and byte_ack=1; byte_ack with byte_valid=0 SHALL be ignored.
REQ-019: A transfer at phase=0 SHALL set phase to 1, with no pointer change.
REQ-020: A transfer at phase=1 SHALL clear phase to 0, advance the read pointer modulo DEPTH and decrement level (this is a pop).
REQ-021: A push SHALL write word_in at the write pointer, advance it modulo DEPTH and increment level.
REQ-022: A push and a pop in the same cycle SHALL leave level unchanged.
REQ-023: Latency SHALL be exactly 1 cycle: a word pushed into an empty FIFO at edge N gives byte_valid=1 with its low byte after edge N.
REQ-024: Sustained throughput SHALL be one byte per cycle while byte_ack is held high.
REQ-025: level SHALL never exceed DEPTH and never underflow below 0.
REQ-026: Pointers SHALL wrap from DEPTH-1 to 0 with no loss or duplication.
REQ-027: enable=0 SHALL, at the next edge, zero both pointers, level, phase and overflow; word_valid and byte_ack SHALL be ignored while enable=0.
REQ-028: Memory contents are not cleared by flush or reset and SHALL NOT be observable, because byte_valid=0.

Reset
REQ-029: rst_n=0 at a clock edge SHALL force pointers=0, level=0, phase=0, overflow=0 and byte_valid=0.
REQ-030: rst_n=0 SHALL take priority over enable, word_valid and byte_ack, including in the middle of a word (phase=1), where the pending high byte is discarded.
REQ-031: byte_out is don't-care during reset.
REQ-032: The first push SHALL be accepted on the first edge with rst_n=1 and enable=1.

Verification
REQ-033: Single word: push 0xA55A into an empty FIFO with ack held high -> bytes 0x5A then 0xA5 on consecutive cycles, level returns 1->0, byte_valid drops.
REQ-034: Fill: DEPTH=8, push 9 words 0x0001..0x0009 with ack=0 -> level=8, overflow=1, and the drained stream is 01 00 02 00 ... 08 00 (0x0009 is absent).
REQ-035: Full with simultaneous pop: level=8 and phase=1, ack=1 and push 0x1234 in the same cycle -> level stays 8, overflow stays 0, and 0x1234 is drained last.
REQ-036: Wrap: 20 words pushed and drained interleaved with random ack at DEPTH=8 -> output byte stream matches the input words in order, low byte first.
REQ-037: Mid-word flush: after the low byte of 0xBEEF is transferred, drop enable for 1 cycle -> level=0, phase=0, overflow=0, byte_valid=0, and 0xBE is never output.
REQ-038: Reset mid-operation: level=5 and overflow=1, then rst_n=0 for 1 cycle -> all outputs at reset values, and the next pushed word 0x00FF is output as FF then 00.
